boot_copy_engine: RTL and testbench
===================================

BOOT_COPY_ENGINE -- requirements
Module: boot_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the width of the source ROM and destination addresses.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the data word width.
REQ-003 SHALL have parameter ROM_LAT, default 1 (legal range 1..4), meaning the ROM read latency in cycles from address to data.
REQ-004 SHALL have parameter AUTO_START, default 1, meaning a copy starts automatically in the first cycle after reset deasserts.
REQ-005 clk_sys  input  1  system clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle copy request.
REQ-008 len  input  ADDR_W+1  number of words to copy, sampled at start.
REQ-009 dst_base  input  ADDR_W  destination base address, sampled at start.
REQ-010 exec_in  input  ADDR_W  execute address, sampled at start.
REQ-011 rom_addr  output  ADDR_W  ROM read address.
REQ-012 rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-013 wr / addr / data  output  1 / ADDR_W / DATA_W  destination write strobe, address and data.
REQ-014 wait_in  input  1  destination backpressure.
REQ-015 busy  output  1  copy in progress.
REQ-016 exec_en / exec_addr  output  1 / ADDR_W  one-cycle completion pulse and registered execute address.

Function
REQ-017 SHALL implement states IDLE, FETCH, WRITE, DONE.
- IDLE -> FETCH on a start request; start requests are ignored outside IDLE.
REQ-018 On start SHALL latch len, dst_base and exec_in, clear the word index idx to 0, and assert busy from the next cycle.
REQ-019 In FETCH SHALL drive rom_addr=idx and wait exactly ROM_LAT cycles, then capture rom_data and enter WRITE.
REQ-020 In WRITE SHALL assert wr with addr=dst_base+idx (modulo 2^ADDR_W) and data equal to the captured word.
REQ-021 A transfer SHALL complete on a cycle with wr=1 and wait_in=0.
- While wait_in=1, wr, addr and data SHALL hold stable.
REQ-022 After each transfer, idx SHALL increment.
- If idx+1==len, go to DONE; otherwise go to FETCH.
- wr SHALL deassert for at least one cycle between transfers.
REQ-023 Exactly len writes SHALL occur, at idx 0..len-1; no write SHALL be issued at idx==len.
REQ-024 len=0 SHALL go from IDLE directly to DONE with no wr pulses.
REQ-025 len=2^ADDR_W SHALL copy the full space; destination addresses wrap from all-ones to 0 without error.
REQ-026 DONE SHALL pulse exec_en for exactly one cycle with exec_addr equal to the latched exec_in.
- busy SHALL drop in the same cycle, then the block returns to IDLE.
- A start in the DONE cycle is ignored.
REQ-027 Worst-case throughput SHALL be one word per ROM_LAT+2 cycles with wait_in=0.

Reset
REQ-028 reset SHALL force state IDLE, and wr=0, exec_en=0, busy=0, rom_addr=0, addr=0, data=0, exec_addr=0, idx=0, from the next clock edge.
REQ-029 Reset asserted mid-copy SHALL abort the copy immediately, with no further wr and no exec_en.
REQ-030 With AUTO_START=1, the first cycle after reset deasserts SHALL act as a start request using the current len, dst_base and exec_in.

Structure
REQ-031 The state enum and the ROM_LAT range limits SHALL live in the shared pcw package.
REQ-032 A single sub-module, rom_lat_pipe (a ROM_LAT-deep valid shift register), SHALL time the FETCH wait.

Verification
REQ-033 len=276, dst_base=0, ROM_LAT=1, wait_in=0 -> 276 wr pulses with addr 0..275 carrying ROM words 0..275, then one exec_en with exec_addr=exec_in, and busy low afterwards.
REQ-034 len=4, wait_in held high for 5 cycles during the 2nd write -> addr=1 and data held stable for all 5 cycles, exactly 4 writes total.
REQ-035 len=0 -> no wr, exec_en one cycle after start.
REQ-036 dst_base=16'hFFFE, len=4 -> write addresses FFFE, FFFF, 0000, 0001.
REQ-037 Reset asserted after the 10th write -> no further wr, no exec_en; with AUTO_START=1, a full copy restarts from idx 0 after reset release.
REQ-038 ROM_LAT=3 and a second start during busy -> data matches the ROM with 3-cycle latency, and the second start is ignored (single exec_en).

Source files
------------

// File: rtl/boot_copy_engine_pkg.sv
// Shared definitions for the boot copy engine: FSM state encoding and ROM latency limits.
package boot_copy_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } bce_state_e;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;

    // Out-of-range latencies are pulled back into the supported window.
    function automatic int clamp_rom_lat(input int lat);
        if (lat < ROM_LAT_MIN) return ROM_LAT_MIN;
        if (lat > ROM_LAT_MAX) return ROM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/boot_copy_engine_if.sv
// ROM read port plus destination write port of the boot copy engine.
interface boot_copy_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wait_in;

    modport master (output rom_addr, wr, addr, data, input rom_data, wait_in);
    modport slave  (input rom_addr, wr, addr, data, output rom_data, wait_in);
endinterface

// File: rtl/boot_copy_engine_rom_lat_pipe.sv
// Valid shift register timing the ROM read: done rises LAT cycles after launch.
module rom_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic launch,
    output logic done
);
    logic [LAT-1:0] vld_pipe_q, vld_pipe_d;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = launch;
        for (int i = 1; i < LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= vld_pipe_d;
    end

    assign done = vld_pipe_q[LAT-1];
endmodule

// File: rtl/boot_copy_engine.sv
// Boot copy engine: copies len ROM words to dst_base, then pulses exec_en with the execute address.
module boot_copy_engine
    import boot_copy_engine_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 1,
    parameter int AUTO_START = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] exec_in,
    output logic              busy,
    output logic              exec_en,
    output logic [ADDR_W-1:0] exec_addr,
    boot_copy_engine_if.master bus
);
    localparam int LAT = clamp_rom_lat(ROM_LAT);

    bce_state_e        state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d, idx_inc;
    logic [ADDR_W-1:0] dst_q, dst_d, rom_addr_q, rom_addr_d, addr_q, addr_d;
    logic [ADDR_W-1:0] exec_addr_q, exec_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d, busy_q, busy_d, exec_en_q, exec_en_d;
    logic              launch_q, launch_d, auto_q, auto_d, lat_done;

    rom_lat_pipe #(.LAT(LAT)) u_lat_pipe (
        .clk_sys (clk_sys),
        .reset   (reset),
        .launch  (launch_q),
        .done    (lat_done)
    );

    // idx is one bit wider than an address so len = 2^ADDR_W terminates.
    assign idx_inc = idx_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        dst_d       = dst_q;
        rom_addr_d  = rom_addr_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = busy_q;
        exec_addr_d = exec_addr_q;
        exec_en_d   = 1'b0;
        launch_d    = 1'b0;
        auto_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    len_d       = len;
                    dst_d       = dst_base;
                    exec_addr_d = exec_in;
                    idx_d       = '0;
                    if (len == '0) begin
                        state_d   = DONE;
                        exec_en_d = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d    = FETCH;
                        busy_d     = 1'b1;
                        rom_addr_d = '0;
                        launch_d   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (lat_done) begin
                    data_d  = bus.rom_data;
                    addr_d  = dst_q + idx_q[ADDR_W-1:0];
                    wr_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Outputs hold by default while the destination stalls.
                if (!bus.wait_in) begin
                    wr_d  = 1'b0;
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d   = DONE;
                        exec_en_d = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d    = FETCH;
                        rom_addr_d = idx_inc[ADDR_W-1:0];
                        launch_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            dst_q       <= '0;
            rom_addr_q  <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            exec_en_q   <= 1'b0;
            exec_addr_q <= '0;
            launch_q    <= 1'b0;
            auto_q      <= (AUTO_START != 0);
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            dst_q       <= dst_d;
            rom_addr_q  <= rom_addr_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            exec_en_q   <= exec_en_d;
            exec_addr_q <= exec_addr_d;
            launch_q    <= launch_d;
            auto_q      <= auto_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.wr       = wr_q;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign busy         = busy_q;
    assign exec_en      = exec_en_q;
    assign exec_addr    = exec_addr_q;
endmodule

// File: tb/tb_boot_copy_engine.sv
// Scoreboard bench: dut A (ROM_LAT=1) and dut B (ROM_LAT=3), both auto-starting after reset.
module tb_boot_copy_engine;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a = 1'b1, start_a = 1'b0, wait_a = 1'b0;
    logic [16:0] len_a = '0;
    logic [15:0] dst_a = '0, exec_in_a = '0;
    logic        busy_a, ee_a;
    logic [15:0] ea_a;
    logic        rst_b = 1'b1, start_b = 1'b0, wait_b = 1'b0;
    logic [16:0] len_b = '0;
    logic [15:0] dst_b = '0, exec_in_b = '0;
    logic        busy_b, ee_b;
    logic [15:0] ea_b;

    boot_copy_engine_if #(.ADDR_W(16), .DATA_W(8)) bus_a();
    boot_copy_engine_if #(.ADDR_W(16), .DATA_W(8)) bus_b();

    boot_copy_engine #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(1), .AUTO_START(1)) u_dut_a (
        .clk_sys(clk), .reset(rst_a), .start(start_a), .len(len_a), .dst_base(dst_a),
        .exec_in(exec_in_a), .busy(busy_a), .exec_en(ee_a), .exec_addr(ea_a), .bus(bus_a));
    boot_copy_engine #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(3), .AUTO_START(1)) u_dut_b (
        .clk_sys(clk), .reset(rst_b), .start(start_b), .len(len_b), .dst_base(dst_b),
        .exec_in(exec_in_b), .busy(busy_b), .exec_en(ee_b), .exec_addr(ea_b), .bus(bus_b));

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return (a[7:0] ^ 8'h3C) + {5'b0, a[10:8]};
    endfunction

    // ROM models with 1- and 3-cycle read latency
    logic [7:0] rom_a_q;
    logic [7:0] rom_b_q [3];
    always @(posedge clk) begin
        rom_a_q    <= rom_fn(bus_a.rom_addr);
        rom_b_q[0] <= rom_fn(bus_b.rom_addr);
        rom_b_q[1] <= rom_b_q[0];
        rom_b_q[2] <= rom_b_q[1];
    end
    assign bus_a.rom_data = rom_a_q;
    assign bus_b.rom_data = rom_b_q[2];
    assign bus_a.wait_in  = wait_a;
    assign bus_b.wait_in  = wait_b;

    wr_t         exp_wr_a[$], exp_wr_b[$];
    logic [15:0] exp_ex_a[$], exp_ex_b[$];
    int   wr_cnt[2], ex_cnt[2], last_cmp[2], stall_cyc[2];
    logic prev_stall[2], prev_ee[2];
    wr_t  prev_w[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic rst, input logic wr, input logic wt,
                       input logic [15:0] addr, input logic [7:0] data,
                       input logic ee, input logic [15:0] ea, input logic busy);
        wr_t got, exp;
        logic [15:0] eexp;
        logic have;
        int gap, lat;
        lat = (k == 0) ? 1 : 3;
        got = {addr, data};
        if (rst) begin
            prev_stall[k] = 1'b0; prev_ee[k] = 1'b0; last_cmp[k] = -1; stall_cyc[k] = 0;
            return;
        end
        if (prev_stall[k]) check($sformatf("hold dut%0d", k), 64'({wr, got}), 64'({1'b1, prev_w[k]}));
        if (wr && !wt) begin
            have = 1'b0; exp = '0;
            if (k == 0 && exp_wr_a.size() > 0) begin exp = exp_wr_a.pop_front(); have = 1'b1; end
            if (k == 1 && exp_wr_b.size() > 0) begin exp = exp_wr_b.pop_front(); have = 1'b1; end
            check($sformatf("write dut%0d (expected-present,addr,data)", k), 64'({have, got}), 64'({1'b1, exp}));
            wr_cnt[k]++;
            if (last_cmp[k] >= 0) begin
                gap = cyc - last_cmp[k] - stall_cyc[k];
                check($sformatf("write spacing dut%0d in range", k), 64'(gap >= 2 && gap <= lat + 2), 64'(1));
            end
            last_cmp[k] = cyc; stall_cyc[k] = 0;
        end
        if (wr && wt) begin stall_cyc[k]++; prev_w[k] = got; end
        prev_stall[k] = wr && wt;
        if (ee) begin
            have = 1'b0; eexp = '0;
            if (k == 0 && exp_ex_a.size() > 0) begin eexp = exp_ex_a.pop_front(); have = 1'b1; end
            if (k == 1 && exp_ex_b.size() > 0) begin eexp = exp_ex_b.pop_front(); have = 1'b1; end
            check($sformatf("exec dut%0d (expected-present,addr,busy,prev_ee)", k),
                  64'({have, ea, busy, prev_ee[k]}), 64'({1'b1, eexp, 1'b0, 1'b0}));
            ex_cnt[k]++; last_cmp[k] = -1; stall_cyc[k] = 0;
        end
        prev_ee[k] = ee;
    endtask

    always @(negedge clk) mon(0, rst_a, bus_a.wr, bus_a.wait_in, bus_a.addr, bus_a.data, ee_a, ea_a, busy_a);
    always @(negedge clk) mon(1, rst_b, bus_b.wr, bus_b.wait_in, bus_b.addr, bus_b.data, ee_b, ea_b, busy_b);

    task automatic push_copy(input int k, input int n, input logic [15:0] dst, input logic [15:0] ex);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = dst + 16'(i);
            w.data = rom_fn(16'(i));
            if (k == 0) exp_wr_a.push_back(w); else exp_wr_b.push_back(w);
        end
        if (k == 0) exp_ex_a.push_back(ex); else exp_ex_b.push_back(ex);
    endtask

    task automatic check_reset(input int k);
        if (k == 0)
            check("reset state dut0", 64'({bus_a.wr, ee_a, busy_a, bus_a.rom_addr, bus_a.addr, bus_a.data, ea_a}), 64'(0));
        else
            check("reset state dut1", 64'({bus_b.wr, ee_b, busy_b, bus_b.rom_addr, bus_b.addr, bus_b.data, ea_b}), 64'(0));
    endtask

    task automatic wait_cnt(input int k, input bit is_ex, input int target, input int max_cyc);
        int c;
        c = is_ex ? ex_cnt[k] : wr_cnt[k];
        for (int i = 0; i < max_cyc && c < target; i++) begin
            @(negedge clk);
            c = is_ex ? ex_cnt[k] : wr_cnt[k];
        end
        check($sformatf("wait dut%0d %s count reached", k, is_ex ? "exec" : "write"), 64'(c >= target), 64'(1));
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1;
        if (k == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        if (k == 0) start_a = 1'b0; else start_b = 1'b0;
    endtask

    int base, exs;

    initial begin
        len_a = 17'd276; dst_a = 16'h0000; exec_in_a = 16'h1234;
        len_b = 17'd3;   dst_b = 16'h0010; exec_in_b = 16'h2222;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);

        // Auto-start copies right after reset release
        push_copy(0, 276, 16'h0000, 16'h1234);
        push_copy(1, 3, 16'h0010, 16'h2222);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        wait_cnt(1, 1, 1, 100);
        wait_cnt(0, 1, 1, 2000);
        repeat (3) @(negedge clk);
        check("long copy busy low", 64'(busy_a), 64'(0));
        check("long copy write count", 64'(wr_cnt[0]), 64'(276));

        // Destination address wraps past all-ones
        len_a = 17'd4; dst_a = 16'hFFFE; exec_in_a = 16'hBEEF;
        push_copy(0, 4, 16'hFFFE, 16'hBEEF);
        pulse_start(0);
        wait_cnt(0, 1, 2, 100);
        check("wrap queue drained", 64'(exp_wr_a.size()), 64'(0));

        // len=0: no writes, exec_en the cycle after start
        len_a = 17'd0; exec_in_a = 16'h0C0D;
        exp_ex_a.push_back(16'h0C0D);
        base = wr_cnt[0];
        pulse_start(0);
        @(negedge clk);
        check("len0 exec_en next cycle", 64'(ee_a), 64'(1));
        check("len0 exec_addr", 64'(ea_a), 64'(16'h0C0D));
        repeat (5) @(negedge clk);
        check("len0 no writes", 64'(wr_cnt[0]), 64'(base));

        // Stall the second write for 5 cycles
        len_a = 17'd4; dst_a = 16'h0000; exec_in_a = 16'h00AB;
        push_copy(0, 4, 16'h0000, 16'h00AB);
        base = wr_cnt[0];
        pulse_start(0);
        wait_cnt(0, 0, base + 1, 50);
        @(posedge clk); #1;
        wait_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.wr) break;
        end
        for (int j = 0; j < 5; j++) begin
            check("stall addr/data/busy", 64'({bus_a.wr, bus_a.addr, bus_a.data, busy_a}),
                  64'({1'b1, 16'h0001, rom_fn(16'h0001), 1'b1}));
            if (j < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        wait_a = 1'b0;
        wait_cnt(0, 1, 4, 100);
        check("stall write count", 64'(wr_cnt[0]), 64'(base + 4));

        // Reset after the 10th write aborts; auto-start restarts from idx 0
        len_a = 17'd20; dst_a = 16'h0400; exec_in_a = 16'h3333;
        push_copy(0, 20, 16'h0400, 16'h3333);
        base = wr_cnt[0];
        exs  = ex_cnt[0];
        pulse_start(0);
        wait_cnt(0, 0, base + 10, 200);
        @(posedge clk); #1;
        rst_a = 1'b1;
        exp_wr_a.delete();
        exp_ex_a.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check("abort exec count", 64'(ex_cnt[0]), 64'(exs));
        len_a = 17'd12; dst_a = 16'h0500; exec_in_a = 16'h6666;
        push_copy(0, 12, 16'h0500, 16'h6666);
        @(posedge clk); #1;
        rst_a = 1'b0;
        wait_cnt(0, 1, exs + 1, 200);
        check("abort+restart write count", 64'(wr_cnt[0]), 64'(base + 10 + 12));
        check("restart queue drained", 64'(exp_wr_a.size()), 64'(0));

        // ROM_LAT=3: start while busy and start in DONE are both ignored
        len_b = 17'd5; dst_b = 16'h0200; exec_in_b = 16'h4444;
        push_copy(1, 5, 16'h0200, 16'h4444);
        base = wr_cnt[1];
        exs  = ex_cnt[1];
        pulse_start(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("dut1 busy during copy", 64'(busy_b), 64'(1));
        len_b = 17'd7; dst_b = 16'h0300; exec_in_b = 16'h5555;
        pulse_start(1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ee_b) break;
        end
        check("dut1 exec_en reached", 64'(ee_b), 64'(1));
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (30) @(negedge clk);
        check("dut1 write count", 64'(wr_cnt[1]), 64'(base + 5));
        check("dut1 single exec", 64'(ex_cnt[1]), 64'(exs + 1));
        check("dut1 idle after", 64'(busy_b), 64'(0));
        check("queues drained", 64'(exp_wr_a.size() + exp_wr_b.size() + exp_ex_a.size() + exp_ex_b.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
